snowflake_timer: RTL



---
 rtl/snowflake_timer_if.sv | 21 ++
 rtl/snowflake_timer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/snowflake_timer_if.sv
// rtl/snowflake_timer_if.sv - system register bus bundle for snowflake_timer (BASE_W address bits)
interface snowflake_timer_if #(
  parameter int BASE_W = 8
);
  logic [BASE_W-1:0] sys_addr;
  logic              sys_en;
  logic              sys_wr_en;
  logic [31:0]       sys_wr_data;
  logic [31:0]       sys_rd_data;
  logic              sys_ack;

  modport master (
    output sys_addr, sys_en, sys_wr_en, sys_wr_data,
    input  sys_rd_data, sys_ack
  );

  modport slave (
    input  sys_addr, sys_en, sys_wr_en, sys_wr_data,
    output sys_rd_data, sys_ack
  );
endinterface

// File: rtl/snowflake_timer.sv
// rtl/snowflake_timer.sv - 64-bit machine timer with prescaler and compare IRQ; optional SNOWFLAKE_TIMER_SHADOW_EN
module snowflake_timer (
  input  logic               clk,
  input  logic               rst,
  snowflake_timer_if.slave   bus,
  output logic               timer_interrupt
);

  logic [31:0] mtime_lo;
  logic [31:0] mtime_hi;
  logic [31:0] mtimecmp_lo;
  logic [31:0] mtimecmp_hi;
  logic        ctrl_en;
  logic [7:0]  ctrl_p;
  logic [7:0]  presc_cnt;
  logic [31:0] rd_mux;

  logic [2:0]  idx;
  logic        rd_req;
  logic        wr_req;
  logic        wr_lo;
  logic        wr_hi;
  logic        wr_ctrl;
  logic        tick;
  logic        carry;
  logic        unused_addr;

  assign idx         = bus.sys_addr[4:2];
  assign unused_addr = ^bus.sys_addr;
  assign rd_req      = bus.sys_en & ~bus.sys_wr_en;
  assign wr_req      = bus.sys_en & bus.sys_wr_en;
  assign wr_lo       = wr_req && (idx == 3'd0);
  assign wr_hi       = wr_req && (idx == 3'd1);
  assign wr_ctrl     = wr_req && (idx == 3'd4);

  // tick comes from the counter value at the start of the cycle; a CTRL write only affects later ticks
  assign tick  = ctrl_en && (presc_cnt == ctrl_p);
  // a LO write in a tick cycle replaces the increment, so it also suppresses the carry into HI
  assign carry = tick && (mtime_lo == 32'hFFFF_FFFF) && !wr_lo;

`ifdef SNOWFLAKE_TIMER_SHADOW_EN
  logic [31:0] mtime_hi_shadow;

  // capture the upper word alongside every MTIME_LO read so a LO/HI pair is atomic
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_hi_shadow <= 32'h0;
    end else if (rd_req && (idx == 3'd0)) begin
      mtime_hi_shadow <= mtime_hi;
    end
  end
`endif

  // read data select from the current register values
  always_comb begin
    rd_mux = 32'h0;
    case (idx)
      3'd0: rd_mux = mtime_lo;
`ifdef SNOWFLAKE_TIMER_SHADOW_EN
      3'd1: rd_mux = mtime_hi_shadow;
`else
      3'd1: rd_mux = mtime_hi;
`endif
      3'd2: rd_mux = mtimecmp_lo;
      3'd3: rd_mux = mtimecmp_hi;
      3'd4: rd_mux = {16'h0, ctrl_p, 7'h0, ctrl_en};
      default: rd_mux = 32'h0;
    endcase
  end

  // mtime counting with write-over-tick priority
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_lo <= 32'h0;
      mtime_hi <= 32'h0;
    end else begin
      if (wr_lo) begin
        mtime_lo <= bus.sys_wr_data;
      end else if (tick) begin
        mtime_lo <= mtime_lo + 32'd1;
      end
      if (wr_hi) begin
        mtime_hi <= bus.sys_wr_data;
      end else if (carry) begin
        mtime_hi <= mtime_hi + 32'd1;
      end
    end
  end

  // compare and control registers plus prescale counter
  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp_lo <= 32'hFFFF_FFFF;
      mtimecmp_hi <= 32'hFFFF_FFFF;
      ctrl_en     <= 1'b0;
      ctrl_p      <= 8'h0;
      presc_cnt   <= 8'h0;
    end else begin
      if (wr_req && (idx == 3'd2)) mtimecmp_lo <= bus.sys_wr_data;
      if (wr_req && (idx == 3'd3)) mtimecmp_hi <= bus.sys_wr_data;
      if (wr_ctrl) begin
        ctrl_en   <= bus.sys_wr_data[0];
        ctrl_p    <= bus.sys_wr_data[15:8];
        presc_cnt <= 8'h0;
      end else if (ctrl_en) begin
        presc_cnt <= tick ? 8'h0 : presc_cnt + 8'd1;
      end
    end
  end

  // bus response and registered interrupt level
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sys_ack     <= 1'b0;
      bus.sys_rd_data <= 32'h0;
      timer_interrupt <= 1'b0;
    end else begin
      bus.sys_ack     <= bus.sys_en;
      if (rd_req) bus.sys_rd_data <= rd_mux;
      timer_interrupt <= {mtime_hi, mtime_lo} >= {mtimecmp_hi, mtimecmp_lo};
    end
  end

endmodule
